knn_topk_stream: RTL

//   Streaming top-K selector for the kNN engine. Per query it accepts N candidate distances, one per cycle.
//   It keeps a sorted register list of the K smallest distances with their arrival indices.
//   It then drains that list in ascending order over a valid/ready port.

---
 rtl/knn_pkg.sv | 18 +
 rtl/knn_topk_insert.sv | 74 +++++++
 rtl/knn_topk_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared FSM state type and default sizing for the streaming top-K selector
//
// The element typedefs depend on the instance parameters, so they are
// declared inside the modules. This package keeps the FSM encoding and the
// default widths, so every file uses the same values.
package knn_pkg;

    localparam int KNN_DEF_DW   = 32;
    localparam int KNN_DEF_K    = 17;
    localparam int KNN_DEF_IDXW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/knn_topk_insert.sv
// rtl/knn_topk_insert.sv - combinational sorted-list insertion for the top-K selector
//
// Ports:
//   list_valid/list_dist/list_idx : current list, slot 0 = smallest distance
//   new_dist/new_idx              : candidate to insert
//   next_valid/next_dist/next_idx : list after insertion (K-1 drops on overflow)
module knn_topk_insert
    import knn_pkg::*;
#(
    parameter int DW   = KNN_DEF_DW,
    parameter int K    = KNN_DEF_K,
    parameter int IDXW = KNN_DEF_IDXW
) (
    input  logic [K-1:0]           list_valid,
    input  logic [K-1:0][DW-1:0]   list_dist,
    input  logic [K-1:0][IDXW-1:0] list_idx,
    input  logic [DW-1:0]          new_dist,
    input  logic [IDXW-1:0]        new_idx,
    output logic [K-1:0]           next_valid,
    output logic [K-1:0][DW-1:0]   next_dist,
    output logic [K-1:0][IDXW-1:0] next_idx
);

    // hit[i]: the candidate belongs at or before slot i. Strict less-than
    // places a tie after the existing entries, so earlier arrivals keep the
    // lower rank.
    logic [K-1:0] hit;
    // therm[i]: the candidate lands at or before slot i. The list is sorted
    // with its valid entries first, so hit is already a thermometer. The
    // prefix OR guarantees that shape, so the shift mux below can rely on it.
    logic [K-1:0] therm;

    always_comb begin
        hit = '0;
        for (int i = 0; i < K; i++) begin
            hit[i] = !list_valid[i] || (new_dist < list_dist[i]);
        end
    end

    always_comb begin
        therm    = '0;
        therm[0] = hit[0];
        for (int i = 1; i < K; i++) begin
            therm[i] = therm[i-1] | hit[i];
        end
    end

    // A slot below the insert point keeps its entry. The insert point takes
    // the candidate. A slot past the insert point takes its upper neighbour.
    always_comb begin
        next_valid = list_valid;
        next_dist  = list_dist;
        next_idx   = list_idx;
        if (therm[0]) begin
            next_valid[0] = 1'b1;
            next_dist[0]  = new_dist;
            next_idx[0]   = new_idx;
        end
        for (int i = 1; i < K; i++) begin
            if (therm[i]) begin
                if (therm[i-1]) begin
                    next_valid[i] = list_valid[i-1];
                    next_dist[i]  = list_dist[i-1];
                    next_idx[i]   = list_idx[i-1];
                end else begin
                    next_valid[i] = 1'b1;
                    next_dist[i]  = new_dist;
                    next_idx[i]   = new_idx;
                end
            end
        end
    end

endmodule

// File: rtl/knn_topk_stream.sv
// rtl/knn_topk_stream.sv - streaming top-K smallest-distance selector with ordered drain
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, n_cand       : query start pulse and candidate count (IDLE only, n_cand != 0)
//   in_valid/in_ready   : candidate handshake, in_dist = candidate distance
//   out_valid/out_ready : result handshake, out_dist/out_idx/out_rank/out_last
//   busy                : query in progress
module knn_topk_stream
    import knn_pkg::*;
#(
    parameter int DW   = KNN_DEF_DW,
    parameter int K    = KNN_DEF_K,
    parameter int IDXW = KNN_DEF_IDXW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IDXW-1:0] n_cand,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_dist,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_dist,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW-1:0] out_rank,
    output logic            out_last,
    output logic            busy
);

    localparam logic [IDXW-1:0] ONE_IDX = IDXW'(1);
    localparam logic [IDXW-1:0] K_IDX   = IDXW'(K);

    state_t                 state;
    logic [IDXW-1:0]        arr_cnt;
    logic [IDXW-1:0]        ncand_q;
    logic [IDXW-1:0]        rank_q;
    // Rank of the final entry, min(K, n_cand) - 1, computed once at start.
    logic [IDXW-1:0]        last_rank;

    logic [K-1:0]           list_valid;
    logic [K-1:0][DW-1:0]   list_dist;
    logic [K-1:0][IDXW-1:0] list_idx;

    logic [K-1:0]           ins_valid;
    logic [K-1:0][DW-1:0]   ins_dist;
    logic [K-1:0][IDXW-1:0] ins_idx;

    knn_topk_insert #(
        .DW   (DW),
        .K    (K),
        .IDXW (IDXW)
    ) u_insert (
        .list_valid (list_valid),
        .list_dist  (list_dist),
        .list_idx   (list_idx),
        .new_dist   (in_dist),
        .new_idx    (arr_cnt),
        .next_valid (ins_valid),
        .next_dist  (ins_dist),
        .next_idx   (ins_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            arr_cnt    <= '0;
            ncand_q    <= '0;
            rank_q     <= '0;
            last_rank  <= '0;
            list_valid <= '0;
            list_dist  <= '0;
            list_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (n_cand != '0)) begin
                        ncand_q    <= n_cand;
                        last_rank  <= (n_cand < K_IDX) ? (n_cand - ONE_IDX) : (K_IDX - ONE_IDX);
                        list_valid <= '0;
                        arr_cnt    <= '0;
                        rank_q     <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // in_ready is high for the whole LOAD state, so in_valid alone
                    // is the handshake.
                    if (in_valid) begin
                        list_valid <= ins_valid;
                        list_dist  <= ins_dist;
                        list_idx   <= ins_idx;
                        arr_cnt    <= arr_cnt + ONE_IDX;
                        if (arr_cnt == ncand_q - ONE_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        // Pop slot 0 by shifting every entry up by one slot.
                        for (int i = 0; i < K - 1; i++) begin
                            list_valid[i] <= list_valid[i+1];
                            list_dist[i]  <= list_dist[i+1];
                            list_idx[i]   <= list_idx[i+1];
                        end
                        list_valid[K-1] <= 1'b0;
                        list_dist[K-1]  <= '0;
                        list_idx[K-1]   <= '0;
                        if (rank_q == last_rank) begin
                            rank_q <= '0;
                            state  <= IDLE;
                        end else begin
                            rank_q <= rank_q + ONE_IDX;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches an output
    // through logic.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign out_dist  = out_valid ? list_dist[0] : '0;
    assign out_idx   = out_valid ? list_idx[0]  : '0;
    assign out_rank  = out_valid ? rank_q       : '0;
    assign out_last  = out_valid && (rank_q == last_rank);

endmodule
